// File: rtl/sw_debounce_if.sv
// Switch bundle between the raw switch inputs and the debounced outputs.
// master drives raw levels; slave is the debouncer producing levels and edge pulses.
interface sw_debounce_if;
    logic [3:0] sw_in;
    logic [3:0] sw_level;
    logic [3:0] sw_press;
    logic [3:0] sw_release;
    logic       sw_any_release;

    modport master (
        output sw_in,
        input  sw_level,
        input  sw_press,
        input  sw_release,
        input  sw_any_release
    );

    modport slave (
        input  sw_in,
        output sw_level,
        output sw_press,
        output sw_release,
        output sw_any_release
    );
endinterface

// File: rtl/sw_debounce.sv
// Four-channel switch debouncer: two-flop synchronizer, per-channel stability counter,
// registered debounced level and one-cycle press/release pulses.
module sw_debounce #(
    parameter int unsigned CNT_MAX = 12000,
    parameter int unsigned CNT_W   = 14
) (
    input logic          clk,
    input logic          rst,
    sw_debounce_if.slave bus
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       level_q, level_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic             any_release_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       hit;

    // A channel qualifies on the edge where its counter is already at the last value
    // and the synchronized input still disagrees with the debounced level.
    always_comb begin
        hit       = '0;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    hit[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (hit[i]) begin
                level_d[i]   = s2_q[i];
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            any_release_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q          <= bus.sw_in;
            s2_q          <= s1_q;
            level_q       <= level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            any_release_q <= |release_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.sw_level       = level_q;
    assign bus.sw_press       = press_q;
    assign bus.sw_release     = release_q;
    assign bus.sw_any_release = any_release_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with CNT_MAX=4: scoreboard of expected pulse events keyed by
// cycle, plus per-cycle invariant checks on pulse shape and counter bounds.
module tb_sw_debounce;

    localparam int Lat = 6;  // drive after edge n -> first sampling edge n+1 -> visible after n+1+CNT_MAX+1

    typedef struct {
        int         cyc;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic       any;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   sb_en = 1'b1;
    ev_t  sb_q[$];
    logic [3:0] press_prev = '0;
    logic [3:0] rel_prev = '0;

    sw_debounce_if bus ();

    sw_debounce #(
        .CNT_MAX(4),
        .CNT_W  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        @(posedge clk);
        #1;
        bus.sw_in = v;
    endtask

    task automatic drive_expect(input logic [3:0] v, input logic [3:0] level,
                                input logic [3:0] press, input logic [3:0] rel);
        ev_t e;
        drive(v);
        e.cyc   = cyc + Lat;
        e.level = level;
        e.press = press;
        e.rel   = rel;
        e.any   = |rel;
        sb_q.push_back(e);
    endtask

    // Monitor samples on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst) begin
            check("rst_level", 32'(bus.sw_level), 32'h0);
            check("rst_press", 32'(bus.sw_press), 32'h0);
            check("rst_release", 32'(bus.sw_release), 32'h0);
            check("rst_any", 32'(bus.sw_any_release), 32'h0);
            press_prev <= '0;
            rel_prev   <= '0;
        end else begin
            check("overlap", 32'(bus.sw_press & bus.sw_release), 32'h0);
            check("press_width", 32'(bus.sw_press & press_prev), 32'h0);
            check("release_width", 32'(bus.sw_release & rel_prev), 32'h0);
            check("any_or", 32'(bus.sw_any_release), 32'(|bus.sw_release));
            for (int i = 0; i < 4; i++) begin
                check("cnt_bound", 32'(dut.cnt_q[i] <= 3'd3), 32'h1);
            end
            press_prev <= bus.sw_press;
            rel_prev   <= bus.sw_release;
            if (sb_en) begin
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                    check("missed_event", 32'(cyc), 32'(sb_q[0].cyc));
                    void'(sb_q.pop_front());
                end
                if ((bus.sw_press != 0) || (bus.sw_release != 0) || bus.sw_any_release) begin
                    if (sb_q.size() == 0) begin
                        check("spurious", {23'h0, bus.sw_press, bus.sw_release,
                                           bus.sw_any_release}, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        check("ev_cycle", 32'(cyc), 32'(e.cyc));
                        check("ev_level", 32'(bus.sw_level), 32'(e.level));
                        check("ev_press", 32'(bus.sw_press), 32'(e.press));
                        check("ev_release", 32'(bus.sw_release), 32'(e.rel));
                        check("ev_any", 32'(bus.sw_any_release), 32'(e.any));
                    end
                end
            end
        end
    end

    initial begin
        bus.sw_in = 4'b0000;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single press on channel 0
        drive_expect(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        repeat (10) @(posedge clk);
        check("level_after_press", 32'(bus.sw_level), 32'h1);

        // Release of channel 0
        drive_expect(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        repeat (10) @(posedge clk);
        check("level_after_release", 32'(bus.sw_level), 32'h0);

        // Bounce on channel 1: 3 cycles high, 1 low, ten times
        for (int k = 0; k < 10; k++) begin
            drive(4'b0010);
            repeat (2) @(posedge clk);
            drive(4'b0000);
        end
        repeat (10) @(posedge clk);
        check("glitch_level", 32'(bus.sw_level), 32'h0);

        // Channels 0 and 3 together up, then together down
        drive_expect(4'b1001, 4'b1001, 4'b1001, 4'b0000);
        repeat (10) @(posedge clk);
        drive_expect(4'b0000, 4'b0000, 4'b0000, 4'b1001);
        repeat (10) @(posedge clk);

        // Press and release on different channels in the same cycle
        drive_expect(4'b0110, 4'b0110, 4'b0110, 4'b0000);
        repeat (10) @(posedge clk);
        drive_expect(4'b0011, 4'b0011, 4'b0001, 4'b0100);
        repeat (10) @(posedge clk);
        drive_expect(4'b0000, 4'b0000, 4'b0000, 4'b0011);
        repeat (10) @(posedge clk);

        // Reset in the middle of a count on channel 2, input held high throughout
        drive(4'b0100);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        begin
            ev_t e;
            e.cyc   = cyc + Lat;
            e.level = 4'b0100;
            e.press = 4'b0100;
            e.rel   = 4'b0000;
            e.any   = 1'b0;
            sb_q.push_back(e);
        end
        repeat (12) @(posedge clk);
        check("level_after_rst", 32'(bus.sw_level), 32'h4);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        // Random stimulus, invariants only
        sb_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            int unsigned hold;
            hold = $urandom_range(1, 6);
            drive(4'($urandom_range(0, 15)));
            repeat (hold - 1) @(posedge clk);
        end
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter CNT_MAX, default 12000, SHALL set the number of consecutive clk cycles a synchronized input must differ from the debounced level before the level updates (1 ms at 12 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 14, SHALL set the width of each per-channel counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sw_in  input  4  raw, asynchronous switch levels; bit i = SWi+1.
REQ-006 sw_level  output  4  debounced, registered switch levels.
REQ-007 sw_press  output  4  one-cycle pulse per channel on debounced 0->1.
REQ-008 sw_release  output  4  one-cycle pulse per channel on debounced 1->0; this is the event consumed by the downstream code-lock state machine.
REQ-009 sw_any_release  output  1  registered OR of the four channels' release conditions, asserted in the same cycle as the sw_release bits.

Function
REQ-010 Each channel SHALL pass sw_in[i] through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-011 Each channel SHALL own an independent CNT_W-bit counter; channels SHALL NOT interact.
REQ-012 When s2 equals sw_level[i], the counter SHALL be cleared to 0.
REQ-013 When s2 differs from sw_level[i] and counter < CNT_MAX-1, the counter SHALL increment by 1.
REQ-014 When s2 differs from sw_level[i] and counter == CNT_MAX-1, then on the same edge: sw_level[i] <= s2, counter <= 0, and the matching pulse (sw_press[i] if s2=1, sw_release[i] if s2=0) <= 1.
REQ-015 Pulse outputs SHALL be registered and high for exactly one cycle per qualified transition; they SHALL be 0 in every other cycle.
REQ-016 Latency: with sw_in[i] changed before edge E0 and held stable, sw_level[i] and the pulse SHALL become visible after edge E0+CNT_MAX+1 (2 synchronizer edges + CNT_MAX count edges, sharing one).
REQ-017 Glitch rejection: any excursion of s2 away from sw_level[i] lasting fewer than CNT_MAX cycles SHALL leave sw_level[i] unchanged and produce no pulse; the counter SHALL restart from 0 on the next excursion.
REQ-018 Simultaneous events: multiple channels qualifying on the same edge SHALL each assert their own pulse in the same cycle; sw_any_release SHALL be 1 if any release bit is 1.
REQ-019 The counter SHALL never exceed CNT_MAX-1 and never wrap.
REQ-020 sw_press[i] and sw_release[i] SHALL never both be 1 in the same cycle.

Reset
REQ-021 While rst=1: s1, s2, counters, sw_level, sw_press, sw_release, sw_any_release SHALL all be 0, applied asynchronously.
REQ-022 Assertion of rst mid-count SHALL discard the count; no pulse SHALL emerge from a count in progress at reset.
REQ-023 After rst deasserts with sw_in held 1, the channel SHALL behave as a fresh 0->1 transition: sw_press[i] pulses once after REQ-016 latency.

Verification (bench uses CNT_MAX=4)
REQ-024 Reset, sw_in=4'b0001 held -> sw_level=4'b0001 and sw_press=4'b0001 for one cycle, 5 edges after first sampling edge; no other pulse.
REQ-025 Channel 0 debounced high, then sw_in[0]=0 held -> sw_release[0]=1 and sw_any_release=1 for exactly one cycle after 5 edges; sw_level[0]=0.
REQ-026 Channel 1 debounced low, sw_in[1] toggles 1 for 3 cycles, 0 for 1, repeated 10 times -> sw_level[1] stays 0, no pulses.
REQ-027 Channels 0 and 3 high, both dropped on the same edge -> sw_release=4'b1001 in one cycle, sw_any_release=1 once.
REQ-028 sw_in[2] raised, rst pulsed after 2 count edges, sw_in[2] then held 1 -> all outputs 0 during rst; sw_press[2] pulses once, 5 edges after rst release.
REQ-029 Any random stimulus -> assertions: pulses one cycle wide, press&release never coincident per channel, counters <= CNT_MAX-1.
